// File: rtl/decode_issue_ctrl.sv
// Decode-stage issue controller: owns ID/EX, inserts load-use bubbles,
// squashes on EX redirect, freezes on MEM wait, counts stalls/flushes.
module decode_issue_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_id_valid,
  input  logic [31:0]      if_id_instr,
  input  logic [31:0]      if_id_pc,
  input  logic [31:0]      imm,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  input  logic             cnt_clear,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             load_use_stall,
  output logic             id_ex_valid,
  output logic             id_ex_mem_read,
  output logic             id_ex_reg_write,
  output logic             id_ex_funct7b5,
  output logic [31:0]      id_ex_pc,
  output logic [31:0]      id_ex_imm,
  output logic [4:0]       id_ex_rs1,
  output logic [4:0]       id_ex_rs2,
  output logic [4:0]       id_ex_rd,
  output logic [6:0]       id_ex_opcode,
  output logic [2:0]       id_ex_funct3,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef struct packed {
    logic        valid;
    logic        mem_read;
    logic        reg_write;
    logic        funct7b5;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
  } id_ex_t;

  id_ex_t           id_ex_d, id_ex_q, dec;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;

  logic [6:0] op;
  logic [4:0] rs1, rs2, rd;
  logic       uses_rs1, uses_rs2, writes_rd;
  logic       hz;

  assign op  = if_id_instr[6:0];
  assign rd  = if_id_instr[11:7];
  assign rs1 = if_id_instr[19:15];
  assign rs2 = if_id_instr[24:20];

  always_comb begin
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL: writes_rd = 1'b1;
      OP_JALR, OP_LD, OP_IMM: begin
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
      end
      OP_BR, OP_ST: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_REG: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        writes_rd = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    dec           = '0;
    dec.valid     = 1'b1;
    dec.mem_read  = (op == OP_LD);
    dec.reg_write = writes_rd & (rd != 5'd0);
    dec.funct7b5  = if_id_instr[30];
    dec.pc        = if_id_pc;
    dec.imm       = imm;
    dec.rs1       = rs1;
    dec.rs2       = rs2;
    dec.rd        = rd;
    dec.opcode    = op;
    dec.funct3    = if_id_instr[14:12];
  end

  // Only a load already sitting in EX can stall the ID instruction.
  assign hz = id_ex_q.valid & id_ex_q.mem_read
            & (id_ex_q.rd != 5'd0) & if_id_valid
            & ((uses_rs1 & (rs1 == id_ex_q.rd))
             | (uses_rs2 & (rs2 == id_ex_q.rd)));

  always_comb begin
    pc_write       = 1'b1;
    if_id_write    = 1'b1;
    if_id_flush    = 1'b0;
    load_use_stall = 1'b0;
    id_ex_d        = id_ex_q;
    stall_cnt_d    = stall_cnt_q;
    flush_cnt_d    = flush_cnt_q;
    priority case (1'b1)
      mem_busy: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
      end
      ex_redirect: begin
        if_id_flush = 1'b1;
        id_ex_d     = '0;
        if (flush_cnt_q != CNT_MAX)
          flush_cnt_d = flush_cnt_q + CNT_ONE;
      end
      hz: begin
        pc_write       = 1'b0;
        if_id_write    = 1'b0;
        load_use_stall = 1'b1;
        id_ex_d        = '0;
        if (stall_cnt_q != CNT_MAX)
          stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
      default: id_ex_d = if_id_valid ? dec : '0;
    endcase
    if (!mem_busy && cnt_clear) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      id_ex_q     <= id_ex_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign id_ex_valid     = id_ex_q.valid;
  assign id_ex_mem_read  = id_ex_q.mem_read;
  assign id_ex_reg_write = id_ex_q.reg_write;
  assign id_ex_funct7b5  = id_ex_q.funct7b5;
  assign id_ex_pc        = id_ex_q.pc;
  assign id_ex_imm       = id_ex_q.imm;
  assign id_ex_rs1       = id_ex_q.rs1;
  assign id_ex_rs2       = id_ex_q.rs2;
  assign id_ex_rd        = id_ex_q.rd;
  assign id_ex_opcode    = id_ex_q.opcode;
  assign id_ex_funct3    = id_ex_q.funct3;
  assign stall_cnt       = stall_cnt_q;
  assign flush_cnt       = flush_cnt_q;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Randomized + directed bench for decode_issue_ctrl against a
// behavioural issue model; CNT_W=4 so counter saturation is reachable.
module tb_decode_issue_ctrl;

  localparam int CW  = 4;
  localparam int MAX = (1 << CW) - 1;

  logic          clk, rst_n;
  logic          if_id_valid, ex_redirect, mem_busy, cnt_clear;
  logic [31:0]   if_id_instr, if_id_pc, imm;
  logic          pc_write, if_id_write, if_id_flush, load_use_stall;
  logic          id_ex_valid, id_ex_mem_read, id_ex_reg_write;
  logic          id_ex_funct7b5;
  logic [31:0]   id_ex_pc, id_ex_imm;
  logic [4:0]    id_ex_rs1, id_ex_rs2, id_ex_rd;
  logic [6:0]    id_ex_opcode;
  logic [2:0]    id_ex_funct3;
  logic [CW-1:0] stall_cnt, flush_cnt;

  decode_issue_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
    .if_id_pc(if_id_pc), .imm(imm),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .cnt_clear(cnt_clear),
    .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .load_use_stall(load_use_stall),
    .id_ex_valid(id_ex_valid), .id_ex_mem_read(id_ex_mem_read),
    .id_ex_reg_write(id_ex_reg_write),
    .id_ex_funct7b5(id_ex_funct7b5),
    .id_ex_pc(id_ex_pc), .id_ex_imm(id_ex_imm),
    .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2),
    .id_ex_rd(id_ex_rd), .id_ex_opcode(id_ex_opcode),
    .id_ex_funct3(id_ex_funct3),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, a, e, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    bit        v, mr, rw, f7;
    bit [31:0] pc, im;
    bit [4:0]  rs1, rs2, rd;
    bit [6:0]  op;
    bit [2:0]  f3;
  } ent_t;

  ent_t m_e;
  int   m_sc, m_fc;

  function automatic bit src1(bit [6:0] o);
    return o inside {7'b1100111, 7'b1100011, 7'b0000011,
                     7'b0100011, 7'b0010011, 7'b0110011};
  endfunction

  function automatic bit src2(bit [6:0] o);
    return o inside {7'b1100011, 7'b0100011, 7'b0110011};
  endfunction

  function automatic bit wr(bit [6:0] o);
    return o inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                     7'b0000011, 7'b0010011, 7'b0110011};
  endfunction

  function automatic ent_t decode(bit v, bit [31:0] i,
                                  bit [31:0] p, bit [31:0] im);
    ent_t e = '0;
    if (!v) return e;
    e.v   = 1'b1;
    e.op  = i[6:0];
    e.rd  = i[11:7];
    e.f3  = i[14:12];
    e.rs1 = i[19:15];
    e.rs2 = i[24:20];
    e.f7  = i[30];
    e.mr  = (e.op == 7'b0000011);
    e.rw  = wr(e.op) && e.rd != 0;
    e.pc  = p;
    e.im  = im;
    return e;
  endfunction

  // 0 freeze, 1 redirect, 2 stall, 3 run
  function automatic int mode();
    ent_t n = decode(if_id_valid, if_id_instr, if_id_pc, imm);
    bit h;
    h = m_e.v && m_e.mr && m_e.rd != 0 && n.v &&
        ((src1(n.op) && n.rs1 == m_e.rd) ||
         (src2(n.op) && n.rs2 == m_e.rd));
    if (mem_busy) return 0;
    if (ex_redirect) return 1;
    if (h) return 2;
    return 3;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_e  <= '0;
      m_sc <= 0;
      m_fc <= 0;
    end else begin
      case (mode())
        1: begin
          m_e  <= '0;
          m_fc <= cnt_clear ? 0 : (m_fc < MAX ? m_fc + 1 : MAX);
          if (cnt_clear) m_sc <= 0;
        end
        2: begin
          m_e  <= '0;
          m_sc <= cnt_clear ? 0 : (m_sc < MAX ? m_sc + 1 : MAX);
          if (cnt_clear) m_fc <= 0;
        end
        3: begin
          m_e <= decode(if_id_valid, if_id_instr, if_id_pc, imm);
          if (cnt_clear) begin
            m_sc <= 0;
            m_fc <= 0;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    int md;
    md = mode();
    chk("pc_write", pc_write, md == 1 || md == 3);
    chk("if_id_write", if_id_write, md == 1 || md == 3);
    chk("if_id_flush", if_id_flush, md == 1);
    chk("load_use_stall", load_use_stall, md == 2);
    chk("id_ex_valid", id_ex_valid, m_e.v);
    chk("id_ex_mem_read", id_ex_mem_read, m_e.mr);
    chk("id_ex_reg_write", id_ex_reg_write, m_e.rw);
    chk("id_ex_funct7b5", id_ex_funct7b5, m_e.f7);
    chk("id_ex_pc", id_ex_pc, m_e.pc);
    chk("id_ex_imm", id_ex_imm, m_e.im);
    chk("id_ex_rs1", id_ex_rs1, m_e.rs1);
    chk("id_ex_rs2", id_ex_rs2, m_e.rs2);
    chk("id_ex_rd", id_ex_rd, m_e.rd);
    chk("id_ex_opcode", id_ex_opcode, m_e.op);
    chk("id_ex_funct3", id_ex_funct3, m_e.f3);
    chk("stall_cnt", stall_cnt, m_sc);
    chk("flush_cnt", flush_cnt, m_fc);
  end

  // ---------------- stimulus ----------------
  localparam logic [31:0] LW5   = 32'h0000A283;
  localparam logic [31:0] ADD65 = 32'h00228333;
  localparam logic [31:0] LW0   = 32'h0000A003;
  localparam logic [31:0] ADD60 = 32'h00200333;
  localparam logic [31:0] LUI5  = 32'h123452B7;

  task automatic drive(bit v, logic [31:0] ins, logic [31:0] im,
                       bit rdr, bit bz, bit cl);
    if_id_valid = v;
    if_id_instr = ins;
    if_id_pc    = $urandom;
    imm         = im;
    ex_redirect = rdr;
    mem_busy    = bz;
    cnt_clear   = cl;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic stall_pairs(int n);
    for (int i = 0; i < n; i++) begin
      drive(1, LW5, 0, 0, 0, 0);
      tick();
      drive(1, ADD65, 0, 0, 0, 0);
      tick();
    end
  endtask

  logic [6:0] ops [10];

  initial begin
    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
            7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1110011};
    rst_n = 1'b0;
    if_id_valid = 0; if_id_instr = 0; if_id_pc = 0; imm = 0;
    ex_redirect = 0; mem_busy = 0; cnt_clear = 0;
    repeat (3) tick();
    rst_n = 1'b1;

    // load-use: one bubble, then the dependent add issues
    drive(1, LW5, 0, 0, 0, 0);
    chk("lw_run_pcw", pc_write, 1);
    tick();
    drive(1, ADD65, 0, 0, 0, 0);
    chk("lu_stall", load_use_stall, 1);
    chk("lu_pcw", pc_write, 0);
    tick();
    chk("lu_bubble", id_ex_valid, 0);
    drive(1, ADD65, 0, 0, 0, 0);
    chk("lu_nostall2", load_use_stall, 0);
    tick();
    chk("lu_rs1", id_ex_rs1, 5);
    chk("lu_rd", id_ex_rd, 6);
    chk("lu_scnt", stall_cnt, 1);

    // x0 destination and non-source consumer never stall
    drive(1, LW0, 0, 0, 0, 0);
    tick();
    drive(1, ADD60, 0, 0, 0, 0);
    chk("x0_nostall", load_use_stall, 0);
    tick();
    drive(1, LW5, 0, 0, 0, 0);
    tick();
    drive(1, LUI5, 32'h12345000, 0, 0, 0);
    chk("lui_nostall", load_use_stall, 0);
    tick();
    chk("lui_rw", id_ex_reg_write, 1);
    chk("lui_imm", id_ex_imm, 32'h12345000);

    // redirect overrides a pending load-use hazard
    drive(1, LW5, 0, 0, 0, 0);
    tick();
    drive(1, ADD65, 0, 1, 0, 0);
    chk("rd_flush", if_id_flush, 1);
    chk("rd_nostall", load_use_stall, 0);
    tick();
    chk("rd_bubble", id_ex_valid, 0);
    chk("rd_fcnt", flush_cnt, 1);
    chk("rd_scnt", stall_cnt, 1);

    // freeze with hazard pending, then exactly one stall
    drive(1, LW5, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, ADD65, 0, 0, 1, 1);
      chk("fz_pcw", pc_write, 0);
      chk("fz_nostall", load_use_stall, 0);
      tick();
      chk("fz_hold_rd", id_ex_rd, 5);
      chk("fz_hold_mr", id_ex_mem_read, 1);
      chk("fz_scnt", stall_cnt, 1);
    end
    drive(1, ADD65, 0, 0, 0, 0);
    chk("fz_then_stall", load_use_stall, 1);
    tick();
    chk("fz_scnt2", stall_cnt, 2);
    drive(1, ADD65, 0, 0, 0, 0);
    tick();

    // randomized traffic, checked by the compare process
    for (int i = 0; i < 600; i++) begin
      logic [31:0] ins;
      ins = {1'b0, 1'($urandom), 5'd0,
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             3'($urandom), 5'($urandom_range(0, 3)),
             ops[$urandom_range(0, 9)]};
      drive($urandom_range(0, 99) < 85, ins, $urandom,
            $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 15,
            $urandom_range(0, 99) < 4);
      tick();
    end

    // saturation and clear
    drive(0, 0, 0, 0, 0, 1);
    tick();
    chk("clr_s", stall_cnt, 0);
    chk("clr_f", flush_cnt, 0);
    stall_pairs(20);
    chk("sat_s", stall_cnt, 15);
    drive(0, 0, 0, 0, 0, 1);
    tick();
    chk("sat_clr", stall_cnt, 0);

    // asynchronous reset mid-operation
    stall_pairs(7);
    drive(1, LW5, 0, 0, 0, 0);
    tick();
    chk("pre_rst_s", stall_cnt, 7);
    chk("pre_rst_v", id_ex_valid, 1);
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_v", id_ex_valid, 0);
    chk("rst_rd", id_ex_rd, 0);
    chk("rst_s", stall_cnt, 0);
    chk("rst_pcw", pc_write, 1);
    chk("rst_ifw", if_id_write, 1);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
